// File: rtl/cu_fsm_gen.sv
// -----------------------------------------------------------------------------
// cu_fsm_gen -- parametrised multi-cycle control unit for the accumulator /
// register datapath. Fetches an instruction word through a ready handshake,
// decodes it and sequences the register file, ALU and data memory through
// the states RST, FETCH, DECODE, EXEC, MEM, WB, BRANCH and HALT.
//
// Every output is registered and is a pure function of the state and of the
// latched instruction fields, so there is no input-to-output combinational
// path.
//
// Parameters:
//   BUS_WIDTH   instruction word width
//   OPCODE_LEN  opcode field width
//   REG_AW      register address field width (NUM_REGS = 2**REG_AW)
//   Word layout, MSB down: opcode, A, B, dest, immediate/target.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   ir          instruction word from imem
//   imem_ready  imem word valid (only looked at in FETCH)
//   dmem_ready  dmem access complete (only looked at in MEM)
//   alu_zero    ALU result == 0 (only looked at while executing JNZ)
//   imem_read   instruction fetch request
//   pc_inc      PC += 1
//   pc_load     PC <= target
//   src_a_sel   one-hot operand-A register enable
//   src_b_sel   one-hot operand-B register enable
//   dst_sel     one-hot destination register select
//   reg_we      register write strobe
//   wb_sel      write-back source: 0 = ALU, 1 = dmem
//   alu_ctrl    ALU operation code
//   dmem_read   data memory read request
//   dmem_write  data memory write request
//   halted      core halted
//   illegal_op  one-cycle pulse in DECODE on an undefined opcode
//
// Build option:
//   CU_ILLEGAL_TRAP_EN  when defined, an undefined opcode halts the core;
//                       otherwise it executes as a NOP.
// -----------------------------------------------------------------------------
module cu_fsm_gen #(
  parameter  int BUS_WIDTH  = 16,
  parameter  int OPCODE_LEN = 4,
  parameter  int REG_AW     = 3,
  localparam int NUM_REGS   = 2**REG_AW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BUS_WIDTH-1:0]  ir,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  alu_zero,
  output logic                  imem_read,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic [NUM_REGS-1:0]   src_a_sel,
  output logic [NUM_REGS-1:0]   src_b_sel,
  output logic [NUM_REGS-1:0]   dst_sel,
  output logic                  reg_we,
  output logic                  wb_sel,
  output logic [3:0]            alu_ctrl,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic                  halted,
  output logic                  illegal_op
);

  localparam int OP_LSB = BUS_WIDTH - OPCODE_LEN;
  localparam int A_LSB  = OP_LSB - REG_AW;
  localparam int B_LSB  = A_LSB - REG_AW;
  localparam int D_LSB  = B_LSB - REG_AW;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_ALU, K_JNZ, K_LOAD, K_STORE, K_JMP, K_HALT, K_ILL
  } kind_t;

  typedef struct packed {
    logic                imem_read;
    logic                pc_inc;
    logic                pc_load;
    logic [NUM_REGS-1:0] src_a_sel;
    logic [NUM_REGS-1:0] src_b_sel;
    logic [NUM_REGS-1:0] dst_sel;
    logic                reg_we;
    logic                wb_sel;
    logic [3:0]          alu_ctrl;
    logic                dmem_read;
    logic                dmem_write;
    logic                halted;
    logic                illegal_op;
  } ctrl_t;

  state_t              state, state_n;
  logic [OPCODE_LEN-1:0] op_q, op_n;
  logic [REG_AW-1:0]   a_q, a_n, b_q, b_n, d_q, d_n;
  ctrl_t               ctrl_q, ctrl_n;

  // The immediate/target bits feed the datapath directly, not this block.
  logic [BUS_WIDTH-1:0] unused_ir;
  assign unused_ir = ir;

  function automatic kind_t op_kind(input logic [OPCODE_LEN-1:0] op);
    case (int'(op))
      0:                   return K_NOP;
      1, 2, 3, 4, 5, 6, 7: return K_ALU;
      8:                   return K_LOAD;
      9:                   return K_STORE;
      10:                  return K_JNZ;
      11:                  return K_JMP;
      15:                  return K_HALT;
      default:             return K_ILL;
    endcase
  endfunction

  // MOVE..INC (opcodes 1..7) map onto ALU codes 0000..0110 in order.
  function automatic logic [3:0] alu_code(input logic [OPCODE_LEN-1:0] op);
    case (int'(op))
      1:       return 4'b0000;
      2:       return 4'b0001;
      3:       return 4'b0010;
      4:       return 4'b0011;
      5:       return 4'b0100;
      6:       return 4'b0101;
      7:       return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_AW-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  // Output image of a state, given the instruction fields valid in it.
  function automatic ctrl_t ctrl_for(input state_t s,
                                     input logic [OPCODE_LEN-1:0] op,
                                     input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b,
                                     input logic [REG_AW-1:0] d);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  c.imem_read = 1'b1;
      S_DECODE: begin
        c.pc_inc     = 1'b1;
        c.illegal_op = (op_kind(op) == K_ILL);
      end
      S_EXEC: begin
        c.src_a_sel = onehot(a);
        // JNZ only passes A through the ALU to produce alu_zero.
        if (op_kind(op) != K_JNZ) begin
          c.src_b_sel = onehot(b);
          c.dst_sel   = onehot(d);
          c.reg_we    = 1'b1;
          c.alu_ctrl  = alu_code(op);
        end
      end
      S_MEM: begin
        c.src_a_sel = onehot(a);
        if (op_kind(op) == K_LOAD) begin
          c.dmem_read = 1'b1;
        end else begin
          c.src_b_sel  = onehot(b);
          c.dmem_write = 1'b1;
        end
      end
      S_WB: begin
        c.dst_sel = onehot(d);
        c.wb_sel  = 1'b1;
        c.reg_we  = 1'b1;
      end
      S_BRANCH: c.pc_load = 1'b1;
      S_HALT:   c.halted  = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    d_n     = d_q;
    case (state)
      S_RST:   state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          state_n = S_DECODE;
          op_n    = ir[OP_LSB +: OPCODE_LEN];
          a_n     = ir[A_LSB +: REG_AW];
          b_n     = ir[B_LSB +: REG_AW];
          d_n     = ir[D_LSB +: REG_AW];
        end
      end
      S_DECODE: begin
        case (op_kind(op_q))
          K_ALU, K_JNZ:    state_n = S_EXEC;
          K_LOAD, K_STORE: state_n = S_MEM;
          K_JMP:           state_n = S_BRANCH;
          K_HALT:          state_n = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
          K_ILL:           state_n = S_HALT;
`else
          K_ILL:           state_n = S_FETCH;
`endif
          default:         state_n = S_FETCH;
        endcase
      end
      S_EXEC: begin
        if (op_kind(op_q) == K_JNZ && !alu_zero) state_n = S_BRANCH;
        else                                     state_n = S_FETCH;
      end
      S_MEM: begin
        if (dmem_ready) state_n = (op_kind(op_q) == K_LOAD) ? S_WB : S_FETCH;
      end
      S_WB, S_BRANCH: state_n = S_FETCH;
      S_HALT:         state_n = S_HALT;
      default:        state_n = S_RST;
    endcase
    // Outputs are precomputed for the state being entered so that they come
    // straight from flops during that state.
    ctrl_n = ctrl_for(state_n, op_n, a_n, b_n, d_n);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_RST;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      a_q    <= a_n;
      b_q    <= b_n;
      d_q    <= d_n;
      ctrl_q <= ctrl_n;
    end
  end

  assign imem_read  = ctrl_q.imem_read;
  assign pc_inc     = ctrl_q.pc_inc;
  assign pc_load    = ctrl_q.pc_load;
  assign src_a_sel  = ctrl_q.src_a_sel;
  assign src_b_sel  = ctrl_q.src_b_sel;
  assign dst_sel    = ctrl_q.dst_sel;
  assign reg_we     = ctrl_q.reg_we;
  assign wb_sel     = ctrl_q.wb_sel;
  assign alu_ctrl   = ctrl_q.alu_ctrl;
  assign dmem_read  = ctrl_q.dmem_read;
  assign dmem_write = ctrl_q.dmem_write;
  assign halted     = ctrl_q.halted;
  assign illegal_op = ctrl_q.illegal_op;

endmodule
